mux_3x1: RTL and testbench
==========================

MUX_3X1 -- requirements
Module: mux_3x1

Interface
REQ-001 Parameter: WIDTH, default 32, bit width of every data input and of DATA_OUT.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous and active-low, sampled on CLK rising edge.
REQ-004 EN  input  1  capture enable; selected data registered only when high.
REQ-005 SELECT  input  2  source select: 2'b00 = DATA_IN_1, 2'b01 = DATA_IN_2, 2'b10 = DATA_IN_3, 2'b11 = illegal.
REQ-006 DATA_IN_1  input  WIDTH  source 1.
REQ-007 DATA_IN_2  input  WIDTH  source 2.
REQ-008 DATA_IN_3  input  WIDTH  source 3.
REQ-009 DATA_OUT  output  WIDTH  registered selected data.
REQ-010 VALID_OUT  output  1  high for one cycle after each legal capture.
REQ-011 SEL_ERR  output  1  high for one cycle after a capture attempt with SELECT = 2'b11.

Function
REQ-012 DATA_OUT, VALID_OUT and SEL_ERR SHALL be driven directly from flops, with no combinational path from any input.
REQ-013 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-014 At an edge with RST_N=1, EN=1 and SELECT in {00,01,10}, the block SHALL capture the addressed DATA_IN_x into DATA_OUT, set VALID_OUT=1 and set SEL_ERR=0.
REQ-015 At an edge with RST_N=1, EN=1 and SELECT=2'b11, the block SHALL hold DATA_OUT, set VALID_OUT=0 and set SEL_ERR=1.
REQ-016 At an edge with RST_N=1 and EN=0, the block SHALL hold DATA_OUT and clear VALID_OUT and SEL_ERR, regardless of SELECT.
REQ-017 VALID_OUT and SEL_ERR SHALL never be high in the same cycle.
REQ-018 Changes on SELECT or DATA_IN_x between edges SHALL have no effect on the outputs.
REQ-019 SELECT changing every cycle with EN held high SHALL produce a new capture every cycle, with no bubbles.
REQ-020 All WIDTH bits SHALL be passed unmodified: no sign extension, truncation or arithmetic.
REQ-021 The block SHALL contain no state other than the output registers (no FSM).

Reset
REQ-022 When RST_N=0 at a CLK rising edge: DATA_OUT=0, VALID_OUT=0, SEL_ERR=0.
REQ-023 Reset SHALL take priority over EN and SELECT.
REQ-024 RST_N SHALL have no effect between clock edges, since reset is synchronous.
REQ-025 The first capture SHALL occur at the first edge with RST_N=1 and EN=1.
REQ-026 Reset asserted mid-stream SHALL clear all outputs at that edge, discarding the capture pending at that edge.

Verification
REQ-027 Reset: DATA_IN_1/2/3 = 1/2/3, RST_N=0 for 2 edges -> DATA_OUT=0, VALID_OUT=0, SEL_ERR=0.
REQ-028 Legal sweep: EN=1, SELECT = 00, 01, 10 on consecutive edges -> DATA_OUT = 1, 2, 3 one cycle later each, with VALID_OUT=1 every cycle.
REQ-029 Illegal select: after DATA_OUT=3, SELECT=11 with EN=1 -> DATA_OUT stays 3, SEL_ERR=1, VALID_OUT=0.
REQ-030 Hold: EN=0, SELECT=00, DATA_IN_1 changed to 32'hFFFF_FFFF -> DATA_OUT unchanged, VALID_OUT=0, SEL_ERR=0.
REQ-031 Width: DATA_IN_2 = 32'hA5A5_5A5A, SELECT=01, EN=1 -> DATA_OUT = 32'hA5A5_5A5A bit-exact.
REQ-032 Mid-stream reset: RST_N=0 with EN=1 and SELECT=10 at the same edge -> all outputs 0 after that edge.

Source files
------------

// File: rtl/mux_3x1.sv
// Registered 3:1 data selector with one-cycle valid and illegal-select error strobes.
// All outputs come straight from flops; the data register is the only held state.
module mux_3x1 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       SELECT,
  input  logic [WIDTH-1:0] DATA_IN_1,
  input  logic [WIDTH-1:0] DATA_IN_2,
  input  logic [WIDTH-1:0] DATA_IN_3,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             SEL_ERR
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sel_err_q, sel_err_d;

  // An illegal select is a rejected capture: data holds and only the error strobe fires.
  always_comb begin
    data_d    = data_q;
    valid_d   = 1'b0;
    sel_err_d = 1'b0;
    if (EN) begin
      unique case (SELECT)
        2'b00: begin
          data_d  = DATA_IN_1;
          valid_d = 1'b1;
        end
        2'b01: begin
          data_d  = DATA_IN_2;
          valid_d = 1'b1;
        end
        2'b10: begin
          data_d  = DATA_IN_3;
          valid_d = 1'b1;
        end
        default: sel_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign SEL_ERR   = sel_err_q;

endmodule

// File: tb/tb_mux_3x1.sv
// Scoreboard bench for mux_3x1: directed scenarios followed by randomized traffic.
// Stimulus pushes expected outputs; an independent monitor pops and compares after each edge.
module tb_mux_3x1;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             err;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             EN = 1'b0;
  logic [1:0]       SELECT = 2'b00;
  logic [WIDTH-1:0] DATA_IN_1 = 32'd1;
  logic [WIDTH-1:0] DATA_IN_2 = 32'd2;
  logic [WIDTH-1:0] DATA_IN_3 = 32'd3;
  logic [WIDTH-1:0] DATA_OUT;
  logic             VALID_OUT;
  logic             SEL_ERR;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] model_data = '0;
  int               n_checks = 0;
  int               n_fail = 0;
  bit               stim_done = 1'b0;

  mux_3x1 #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .SELECT    (SELECT),
    .DATA_IN_1 (DATA_IN_1),
    .DATA_IN_2 (DATA_IN_2),
    .DATA_IN_3 (DATA_IN_3),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .SEL_ERR   (SEL_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference behaviour: sources as an array indexed by select; index 3 means "rejected".
  function automatic exp_t model_step(input logic rst_n, input logic en, input logic [1:0] sel,
                                      input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                                      input logic [WIDTH-1:0] d3);
    logic [WIDTH-1:0] src [3];
    exp_t e;
    src[0] = d1;
    src[1] = d2;
    src[2] = d3;
    if (!rst_n) begin
      model_data = '0;
      e = '{data: '0, valid: 1'b0, err: 1'b0};
    end else if (!en) begin
      e = '{data: model_data, valid: 1'b0, err: 1'b0};
    end else if (sel == 2'd3) begin
      e = '{data: model_data, valid: 1'b0, err: 1'b1};
    end else begin
      model_data = src[sel];
      e = '{data: model_data, valid: 1'b1, err: 1'b0};
    end
    return e;
  endfunction

  task automatic drive(input logic rst_n, input logic en, input logic [1:0] sel,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                       input logic [WIDTH-1:0] d3);
    @(negedge CLK);
    RST_N     = rst_n;
    EN        = en;
    SELECT    = sel;
    DATA_IN_1 = d1;
    DATA_IN_2 = d2;
    DATA_IN_3 = d3;
    sb_q.push_back(model_step(rst_n, en, sel, d1, d2, d3));
  endtask

  // Between-edge disturbance: inputs and reset wiggle after the sampling point and before the next drive.
  task automatic glitch();
    @(posedge CLK);
    #3;
    SELECT    = 2'($urandom_range(0, 3));
    DATA_IN_1 = $urandom;
    DATA_IN_2 = $urandom;
    DATA_IN_3 = $urandom;
    EN        = ~EN;
    RST_N     = 1'b0;
    #1;
    RST_N     = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (DATA_OUT !== e.data) begin
          n_fail++;
          $display("FAIL data_out: got %h expected %h at %0t", DATA_OUT, e.data, $time);
        end
        n_checks++;
        if (VALID_OUT !== e.valid) begin
          n_fail++;
          $display("FAIL valid_out: got %b expected %b at %0t", VALID_OUT, e.valid, $time);
        end
        n_checks++;
        if (SEL_ERR !== e.err) begin
          n_fail++;
          $display("FAIL sel_err: got %b expected %b at %0t", SEL_ERR, e.err, $time);
        end
        n_checks++;
        if (VALID_OUT === 1'b1 && SEL_ERR === 1'b1) begin
          n_fail++;
          $display("FAIL exclusive: valid_out %b and sel_err %b both high at %0t",
                   VALID_OUT, SEL_ERR, $time);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    logic rst_n, en;

    drive(1'b0, 1'b1, 2'b00, 32'd1, 32'd2, 32'd3);
    drive(1'b0, 1'b0, 2'b10, 32'd1, 32'd2, 32'd3);
    drive(1'b1, 1'b1, 2'b00, 32'd1, 32'd2, 32'd3);
    drive(1'b1, 1'b1, 2'b01, 32'd1, 32'd2, 32'd3);
    drive(1'b1, 1'b1, 2'b10, 32'd1, 32'd2, 32'd3);
    drive(1'b1, 1'b1, 2'b11, 32'd1, 32'd2, 32'd3);
    drive(1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd3);
    drive(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd3);
    drive(1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'd3);
    drive(1'b1, 1'b1, 2'b00, 32'h8000_0001, 32'hA5A5_5A5A, 32'd3);
    drive(1'b0, 1'b1, 2'b10, 32'h8000_0001, 32'hA5A5_5A5A, 32'h7777_7777);
    drive(1'b1, 1'b1, 2'b10, 32'h8000_0001, 32'hA5A5_5A5A, 32'h7777_7777);

    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      en    = ($urandom_range(0, 3) != 0);
      drive(rst_n, en, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      if (rst_n && $urandom_range(0, 7) == 0) glitch();
    end

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
